// File: rtl/uart_rx_pkg.sv
// Shared UART receive types and constants: FSM states, bit timing at 50 MHz / 38400 baud.
package uart_pkg;

  localparam int unsigned DEFAULT_DATA_BITS = 8;
  localparam int unsigned BIT_PERIOD        = 1302;
  localparam int unsigned HALF_PERIOD       = 651;
  localparam int unsigned MID_COUNT         = 650;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // True when data plus parity bit carry an even number of ones.
  function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
    return ~(^{data, par});
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial-side and byte-side signals of the UART receiver; master is the receiver itself.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS
);

  logic                 rx_in;
  logic                 baud_pulse;
  logic                 baud_en;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 parity_err;

  modport master (
    input  rx_in,
    input  baud_pulse,
    input  rx_ready,
    output baud_en,
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output parity_err
  );

  modport slave (
    output rx_in,
    output baud_pulse,
    output rx_ready,
    input  baud_en,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  parity_err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Metastability flop chain for an asynchronous, idle-high serial line; resets to 1.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      chain_q <= '1;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receive framer with a one-entry ready/valid output buffer.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  localparam int unsigned CntW = $clog2(DATA_BITS);

  logic                 rx_s;
  logic                 rx_prev_q;
  uart_state_e          state_q;
  logic [CntW-1:0]      bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 baud_en_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 par_ok;
  logic                 start_edge;
  logic                 can_load;
  logic                 last_bit;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (bus.rx_in),
    .q  (rx_s)
  );

  // rx_prev must see the line high before a new start is accepted.
  assign start_edge = rx_prev_q & ~rx_s;
  assign can_load   = ~rx_valid_q | bus.rx_ready;
  assign last_bit   = (bit_cnt_q == CntW'(DATA_BITS - 1));

`ifdef UART_RX_PARITY_EN
  logic par_q;
  logic parity_err_q;
  assign par_ok         = even_parity_ok(8'(shift_q), par_q);
  assign bus.parity_err = parity_err_q;
`else
  assign par_ok         = 1'b1;
  assign bus.parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_prev_q    <= 1'b1;
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      baud_en_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_prev_q   <= rx_s;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (rx_valid_q && bus.rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (start_edge) begin
            state_q   <= StStart;
            baud_en_q <= 1'b1;
          end
        end

        StStart: begin
          if (bus.baud_pulse) begin
            if (rx_s) begin
              state_q   <= StIdle;
              baud_en_q <= 1'b0;
            end else begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end
          end
        end

        StData: begin
          if (bus.baud_pulse) begin
            shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (last_bit) begin
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (bus.baud_pulse) begin
            par_q   <= rx_s;
            state_q <= StStop;
          end
        end
`endif

        StStop: begin
          if (bus.baud_pulse) begin
            state_q     <= StIdle;
            baud_en_q   <= 1'b0;
            frame_err_q <= ~rx_s;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= ~par_ok;
`endif
            if (rx_s && par_ok) begin
              if (can_load) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end
          end
        end

        default: begin
          state_q   <= StIdle;
          baud_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.baud_en   = baud_en_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx driven by a midpoint-sampling baud generator model.
`timescale 1ns / 1ps
module tb_uart_rx;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(
    .DATA_BITS  (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Baud generator: counter cleared while baud_en is low, pulse at the bit midpoint.
  int unsigned bit_per = BIT_PERIOD;
  int unsigned baud_cnt = 0;
  always @(posedge clk) begin
    if (!rst || !bus.baud_en) baud_cnt <= 0;
    else if (baud_cnt == bit_per - 1) baud_cnt <= 0;
    else baud_cnt <= baud_cnt + 1;
  end
  assign bus.baud_pulse = bus.baud_en && (baud_cnt == bit_per / 2 - 1);

  logic line = 1'b1;
  logic ready_lvl = 1'b1;
  logic pulse_mode = 1'b0;
  logic in_stop = 1'b0;
  assign bus.rx_in    = line;
  assign bus.rx_ready = pulse_mode ? (in_stop && bus.baud_pulse) : ready_lvl;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, wide_cnt = 0;
  int exp_fe = 0, exp_ov = 0, exp_pe = 0;
  logic prev_fe = 1'b0, prev_ov = 1'b0, prev_pe = 1'b0;
  logic hold_v = 1'b0;
  logic [7:0] hold_d = '0;

  // Monitor: pops the scoreboard on each accepted byte, tallies error pulses.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.rx_valid && bus.rx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rx_data_unexpected: got %h, required no byte", bus.rx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (bus.rx_data !== exp_b) begin
            errors++;
            $display("FAIL rx_data: got %h, required %h", bus.rx_data, exp_b);
          end
        end
      end
      if (hold_v && bus.rx_valid) begin
        checks++;
        if (bus.rx_data !== hold_d) begin
          errors++;
          $display("FAIL rx_data_stable: got %h, required %h", bus.rx_data, hold_d);
        end
      end
      if (bus.frame_err) fe_cnt++;
      if (bus.overrun) ov_cnt++;
      if (bus.parity_err) pe_cnt++;
      if ((prev_fe && bus.frame_err) || (prev_ov && bus.overrun) ||
          (prev_pe && bus.parity_err)) wide_cnt++;
    end
    hold_v  = bus.rx_valid && !bus.rx_ready;
    hold_d  = bus.rx_data;
    prev_fe = bus.frame_err;
    prev_ov = bus.overrun;
    prev_pe = bus.parity_err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic drive_bit(input logic b);
    line = b;
    repeat (bit_per) @(negedge clk);
  endtask

  function automatic logic par_of(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`else
    if (par_bit === 1'bx) line = 1'b0;
`endif
    in_stop = 1'b1;
    drive_bit(stop_bit);
    in_stop = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en_hi;
    int wait_n;
    repeat (3) @(negedge clk);
    check("reset_baud_en", 32'(bus.baud_en), 0);
    check("reset_rx_valid", 32'(bus.rx_valid), 0);
    check("reset_rx_data", 32'(bus.rx_data), 0);
    check("reset_errs", {29'b0, bus.frame_err, bus.overrun, bus.parity_err}, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Clean 0xA5 at the full 1302-clock bit period.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, par_of(8'hA5));
    repeat (3) @(negedge clk);
    check("a5_baud_en_after_stop", 32'(bus.baud_en), 0);
    check("a5_delivered", 32'(exp_q.size()), 0);
    check("a5_no_frame_err", 32'(fe_cnt), 32'(exp_fe));

    // False start: 100 clocks low, then high.
    line = 1'b0;
    repeat (100) @(negedge clk);
    line = 1'b1;
    repeat (400) @(negedge clk);
    check("false_start_baud_en_on", 32'(bus.baud_en), 1);
    repeat (300) @(negedge clk);
    check("false_start_baud_en_off", 32'(bus.baud_en), 0);
    check("false_start_no_valid", 32'(bus.rx_valid), 0);

    // Shorter bit period for the remaining frames keeps the run brief.
    bit_per = 130;

    // Bad stop bit, line then held low.
    exp_fe++;
    send_frame(8'h3C, 1'b0, par_of(8'h3C));
    en_hi = 0;
    for (int i = 0; i < 20 * 130; i++) begin
      @(negedge clk);
      if (bus.baud_en) en_hi++;
    end
    check("stop_low_frame_err", 32'(fe_cnt), 32'(exp_fe));
    check("stop_low_no_valid", 32'(bus.rx_valid), 0);
    check("held_low_no_retrigger", 32'(en_hi), 0);
    line = 1'b1;
    repeat (2 * bit_per) @(negedge clk);

    // Overrun: buffer full with 0x11, 0x22 dropped.
    ready_lvl = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, par_of(8'h11));
    exp_ov++;
    send_frame(8'h22, 1'b1, par_of(8'h22));
    repeat (5) @(negedge clk);
    check("overrun_pulse", 32'(ov_cnt), 32'(exp_ov));
    check("overrun_kept_data", 32'(bus.rx_data), 32'h11);
    check("overrun_kept_valid", 32'(bus.rx_valid), 1);
    ready_lvl = 1'b1;
    repeat (3) @(negedge clk);
    check("overrun_drained", 32'(bus.rx_valid), 0);

    // Drain coinciding with delivery: 0x22 replaces 0x11, no overrun.
    ready_lvl = 1'b0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, par_of(8'h11));
    pulse_mode = 1'b1;
    send_frame(8'h22, 1'b1, par_of(8'h22));
    pulse_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("coincide_data", 32'(bus.rx_data), 32'h22);
    check("coincide_valid", 32'(bus.rx_valid), 1);
    check("coincide_no_overrun", 32'(ov_cnt), 32'(exp_ov));
    ready_lvl = 1'b1;
    repeat (3) @(negedge clk);

    // Reset in the middle of the data bits of 0xFF.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    check("mid_frame_baud_en", 32'(bus.baud_en), 1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_reset_baud_en", 32'(bus.baud_en), 0);
    check("mid_reset_valid", 32'(bus.rx_valid), 0);
    check("mid_reset_state", 32'(dut.state_q), 32'(StIdle));
    rst = 1'b1;
    line = 1'b1;
    repeat (2 * bit_per) @(negedge clk);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, par_of(8'h5A));
    repeat (5) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    exp_pe++;
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    check("parity_bad_no_valid", 32'(bus.rx_valid), 0);
`endif

    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    check("frame_err_total", 32'(fe_cnt), 32'(exp_fe));
    check("overrun_total", 32'(ov_cnt), 32'(exp_ov));
    check("parity_err_total", 32'(pe_cnt), 32'(exp_pe));
    check("pulse_width", 32'(wide_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
